// File: rtl/vsa_mem_pkg.sv
// Shared types and sizes for the VSA memory responder: FSM states, memory depth and word widths.
package vsa_mem_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int INSTR_W   = 12;
    localparam int DATA_W    = 5;
    localparam int COUNT_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/vsa_mem_responder_if.sv
// Processor fetch/data bus plus loader valid/ready channel and status outputs of the responder.
interface vsa_mem_responder_if;
    import vsa_mem_pkg::*;

    logic [ADDR_W-1:0]  PC;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  ALUOutput;
    logic [DATA_W-1:0]  datain;
    logic [DATA_W-1:0]  dataout;
    logic               wr;

    logic               ld_valid;
    logic               ld_ready;
    logic               ld_target;
    logic [ADDR_W-1:0]  ld_addr;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_last;

    logic               run;
    logic [COUNT_W-1:0] ld_count;
    logic               wr_fault;

    modport slave (
        input  PC, ALUOutput, dataout, wr,
        input  ld_valid, ld_target, ld_addr, ld_data, ld_last,
        output instruction, datain, ld_ready, run, ld_count, wr_fault
    );

    modport master (
        output PC, ALUOutput, dataout, wr,
        output ld_valid, ld_target, ld_addr, ld_data, ld_last,
        input  instruction, datain, ld_ready, run, ld_count, wr_fault
    );

endinterface

// File: rtl/vsa_ram.sv
// 32-deep RAM of parameterised width: synchronous write, asynchronous read, synchronous clear.
module vsa_ram
    import vsa_mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [MEM_DEPTH];

    // Clear wins over a same-cycle write.
    always_ff @(posedge clock) begin
        if (clear_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vsa_mem_responder.sv
// Memory responder for a small processor: loader fills imem/dmem, then the processor runs until reset.
module vsa_mem_responder
    import vsa_mem_pkg::*;
#(
    parameter bit IMEM_INIT_ZERO = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    vsa_mem_responder_if.slave   bus
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] ldCount_q, ldCount_d;
    logic               wrFault_q, wrFault_d;

    logic               accept;
    logic               imemWe;
    logic               dmemWe;
    logic [ADDR_W-1:0]  dmemAddr;
    logic [DATA_W-1:0]  dmemWdata;
    logic [INSTR_W-1:0] imemRdata;

    assign accept = bus.ld_valid && (state_q != RUN);

    always_comb begin
        state_d   = state_q;
        ldCount_d = ldCount_q;
        wrFault_d = wrFault_q;
        imemWe    = 1'b0;
        dmemWe    = 1'b0;
        dmemAddr  = bus.ALUOutput;
        dmemWdata = bus.dataout;

        if (accept) begin
            state_d = bus.ld_last ? RUN : LOAD;
            if (ldCount_q != COUNT_MAX) begin
                ldCount_d = ldCount_q + 1'b1;
            end
            if (bus.ld_target) begin
                dmemWe    = reset_n;
                dmemAddr  = bus.ld_addr;
                dmemWdata = bus.ld_data[DATA_W-1:0];
            end else begin
                imemWe = reset_n;
            end
        end

        // Processor writes only land in RUN; anywhere else they are dropped and flagged.
        if (bus.wr) begin
            if (state_q == RUN) begin
                dmemWe = reset_n;
            end else begin
                wrFault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ldCount_q <= '0;
            wrFault_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ldCount_q <= ldCount_d;
            wrFault_q <= wrFault_d;
        end
    end

    vsa_ram #(.WIDTH(INSTR_W)) u_imem (
        .clock   (clock),
        .clear_i (!reset_n && IMEM_INIT_ZERO),
        .we_i    (imemWe),
        .waddr_i (bus.ld_addr),
        .wdata_i (bus.ld_data),
        .raddr_i (bus.PC),
        .rdata_o (imemRdata)
    );

    vsa_ram #(.WIDTH(DATA_W)) u_dmem (
        .clock   (clock),
        .clear_i (!reset_n),
        .we_i    (dmemWe),
        .waddr_i (dmemAddr),
        .wdata_i (dmemWdata),
        .raddr_i (bus.ALUOutput),
        .rdata_o (bus.datain)
    );

    assign bus.instruction = (state_q == RUN) ? imemRdata : '0;
    assign bus.ld_ready    = (state_q != RUN);
    assign bus.run         = (state_q == RUN);
    assign bus.ld_count    = ldCount_q;
    assign bus.wr_fault    = wrFault_q;

endmodule

// File: tb/tb_vsa_mem_responder.sv
// Directed self-checking bench for vsa_mem_responder with hand-computed expectations.
module tb_vsa_mem_responder;

    logic clock;
    logic reset_n;
    int   vecCount;
    int   missCount;

    vsa_mem_responder_if bus ();

    vsa_mem_responder #(.IMEM_INIT_ZERO(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One loader beat held for exactly one rising edge.
    task automatic applyStimulus(input logic target, input logic [4:0] addr,
                                 input logic [11:0] data, input logic last);
        bus.ld_valid  = 1'b1;
        bus.ld_target = target;
        bus.ld_addr   = addr;
        bus.ld_data   = data;
        bus.ld_last   = last;
        tick();
        bus.ld_valid  = 1'b0;
        bus.ld_last   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        vecCount     = 0;
        missCount    = 0;
        reset_n      = 1'b0;
        bus.PC        = '0;
        bus.ALUOutput = '0;
        bus.dataout   = '0;
        bus.wr        = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_target = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.ld_last   = 1'b0;
        tick();
        doReset();

        checkOutput("rst_run",      32'(bus.run),         32'd0);
        checkOutput("rst_ready",    32'(bus.ld_ready),    32'd1);
        checkOutput("rst_count",    32'(bus.ld_count),    32'd0);
        checkOutput("rst_fault",    32'(bus.wr_fault),    32'd0);
        checkOutput("rst_instr",    32'(bus.instruction), 32'h000);
        checkOutput("rst_datain",   32'(bus.datain),      32'd0);

        // Three imem beats, last on the third.
        applyStimulus(1'b0, 5'd0, 12'h601, 1'b0);
        applyStimulus(1'b0, 5'd2, 12'h818, 1'b0);
        checkOutput("load_run",     32'(bus.run),         32'd0);
        checkOutput("load_ready",   32'(bus.ld_ready),    32'd1);
        checkOutput("load_instr",   32'(bus.instruction), 32'h000);
        applyStimulus(1'b0, 5'd4, 12'hE00, 1'b1);
        checkOutput("run_count",    32'(bus.ld_count),    32'd3);
        checkOutput("run_run",      32'(bus.run),         32'd1);
        checkOutput("run_ready",    32'(bus.ld_ready),    32'd0);
        bus.PC = 5'd2; #1;
        checkOutput("instr_pc2",    32'(bus.instruction), 32'h818);
        bus.PC = 5'd3; #1;
        checkOutput("instr_pc3",    32'(bus.instruction), 32'h000);
        bus.PC = 5'd4; #1;
        checkOutput("instr_pc4",    32'(bus.instruction), 32'hE00);
        bus.PC = 5'd0; #1;
        checkOutput("instr_pc0",    32'(bus.instruction), 32'h601);

        // Loader beat offered in RUN must be ignored.
        bus.ld_valid  = 1'b1;
        bus.ld_target = 1'b0;
        bus.ld_addr   = 5'd2;
        bus.ld_data   = 12'h123;
        #1;
        checkOutput("runbeat_ready", 32'(bus.ld_ready),   32'd0);
        tick();
        bus.ld_valid = 1'b0;
        checkOutput("runbeat_count", 32'(bus.ld_count),   32'd3);
        bus.PC = 5'd2; #1;
        checkOutput("runbeat_imem",  32'(bus.instruction), 32'h818);
        checkOutput("runbeat_run",   32'(bus.run),         32'd1);

        // Processor write in RUN: old value in the write cycle, new value after.
        bus.wr        = 1'b1;
        bus.ALUOutput = 5'd5;
        bus.dataout   = 5'd17;
        #1;
        checkOutput("wr_same_cycle", 32'(bus.datain),     32'd0);
        tick();
        bus.wr = 1'b0;
        #1;
        checkOutput("wr_next_cycle", 32'(bus.datain),     32'd17);
        checkOutput("wr_run_nofault", 32'(bus.wr_fault),  32'd0);

        doReset();
        checkOutput("rst2_dmem5",   32'(bus.datain),      32'd0);
        checkOutput("rst2_run",     32'(bus.run),         32'd0);
        checkOutput("rst2_count",   32'(bus.ld_count),    32'd0);

        // Write in IDLE is dropped and latches the fault flag.
        bus.wr        = 1'b1;
        bus.ALUOutput = 5'd3;
        bus.dataout   = 5'd9;
        tick();
        bus.wr = 1'b0;
        #1;
        checkOutput("idlewr_dmem3", 32'(bus.datain),      32'd0);
        checkOutput("idlewr_fault", 32'(bus.wr_fault),    32'd1);

        // dmem beat keeps only the low five data bits.
        applyStimulus(1'b1, 5'd31, 12'hFFF, 1'b0);
        bus.ALUOutput = 5'd31; #1;
        checkOutput("dmem31",       32'(bus.datain),      32'h1F);
        checkOutput("fault_sticky", 32'(bus.wr_fault),    32'd1);
        checkOutput("dmembeat_cnt", 32'(bus.ld_count),    32'd1);
        checkOutput("dmembeat_rdy", 32'(bus.ld_ready),    32'd1);

        // Reset mid-LOAD discards progress and clears both memories.
        doReset();
        checkOutput("midload_dmem", 32'(bus.datain),      32'd0);
        checkOutput("midload_rdy",  32'(bus.ld_ready),    32'd1);
        checkOutput("midload_run",  32'(bus.run),         32'd0);
        checkOutput("midload_flt",  32'(bus.wr_fault),    32'd0);
        checkOutput("midload_ins",  32'(bus.instruction), 32'h000);
        applyStimulus(1'b1, 5'd0, 12'h000, 1'b1);
        checkOutput("direct_run",   32'(bus.run),         32'd1);
        bus.PC = 5'd0; #1;
        checkOutput("imem_clr_pc0", 32'(bus.instruction), 32'h000);
        bus.PC = 5'd2; #1;
        checkOutput("imem_clr_pc2", 32'(bus.instruction), 32'h000);

        // Write collides with an accepted beat in LOAD: loader write wins, fault set.
        doReset();
        applyStimulus(1'b0, 5'd1, 12'h7AB, 1'b0);
        bus.wr        = 1'b1;
        bus.ALUOutput = 5'd6;
        bus.dataout   = 5'h15;
        applyStimulus(1'b1, 5'd6, 12'h00A, 1'b0);
        bus.wr = 1'b0;
        #1;
        checkOutput("collide_dmem", 32'(bus.datain),      32'h0A);
        checkOutput("collide_flt",  32'(bus.wr_fault),    32'd1);
        checkOutput("collide_cnt",  32'(bus.ld_count),    32'd2);

        // Counter saturation over 70 beats without ld_last.
        doReset();
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b1, 5'(i % 32), 12'(i * 3), 1'b0);
            if (i == 62) begin
                checkOutput("count_at63", 32'(bus.ld_count), 32'd63);
            end
        end
        checkOutput("sat_count",    32'(bus.ld_count),    32'd63);
        checkOutput("sat_ready",    32'(bus.ld_ready),    32'd1);
        checkOutput("sat_run",      32'(bus.run),         32'd0);
        bus.ALUOutput = 5'd10; #1;
        checkOutput("sat_dmem10",   32'(bus.datain),      32'd30);

        // Odd top address works for fetch.
        applyStimulus(1'b0, 5'd31, 12'hABC, 1'b1);
        bus.PC = 5'd31; #1;
        checkOutput("pc31",         32'(bus.instruction), 32'hABC);
        checkOutput("pc31_run",     32'(bus.run),         32'd1);
        checkOutput("pc31_count",   32'(bus.ld_count),    32'd63);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
